// File: rtl/pll_spi_loader_if.sv
// Bundle between the PLL loader and its surroundings: control handshake,
// configuration-table fetch port and the PLL 3-wire SPI / lock-detect pins.
interface pll_spi_loader_if #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 24
);
  logic              start;
  logic              busy;
  logic              locked;
  logic              error;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_data;
  logic              pll_sck;
  logic              pll_sen;
  logic              pll_sdi;
  logic              pll_ld_sdo;

  modport master (
    input  start, cfg_data, pll_ld_sdo,
    output busy, locked, error, cfg_addr, pll_sck, pll_sen, pll_sdi
  );

  modport slave (
    output start, cfg_data, pll_ld_sdo,
    input  busy, locked, error, cfg_addr, pll_sck, pll_sen, pll_sdi
  );
endinterface

// File: rtl/pll_spi_loader.sv
// Streams a table of configuration words into the board PLL over 3-wire SPI,
// then waits for a stable lock-detect and reloads the whole table on timeout.
module pll_spi_loader #(
  parameter int NWORDS       = 8,
  parameter int WORD_W       = 24,
  parameter int CLK_DIV      = 4,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_spi_loader_if.master   bus
);

  localparam int ADDR_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PH_W     = $clog2(2 * CLK_DIV);
  localparam int BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W     = $clog2(LOCK_STABLE + 1);
  localparam int RT_W     = $clog2(MAX_RETRY + 2);
  // Between words FETCH and LOAD already contribute two sen-high cycles.
  localparam int HOP      = 2 * CLK_DIV - 2;
  localparam int HOP_LAST = (HOP > 0) ? HOP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_WAIT_LOCK, S_DONE, S_FAIL
  } state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [WORD_W-1:0]  shift_reg;
  logic [PH_W-1:0]    phase_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               tail_reg;
  logic [TO_W-1:0]    timeout_cnt;
  logic [ST_W-1:0]    stable_cnt;
  logic [RT_W-1:0]    retry_cnt;
  logic               busy_reg, locked_reg, error_reg;
  logic               sck_reg, sen_reg, sdi_reg;
  logic               ld_meta_reg, ld_sync_reg;
  logic [WORD_W-1:0]  shift_next;
  logic               last_word;

  assign shift_next = shift_reg << 1;
  assign last_word  = (addr_reg == ADDR_W'(NWORDS - 1));

  assign bus.cfg_addr = addr_reg;
  assign bus.busy     = busy_reg;
  assign bus.locked   = locked_reg;
  assign bus.error    = error_reg;
  assign bus.pll_sck  = sck_reg;
  assign bus.pll_sen  = sen_reg;
  assign bus.pll_sdi  = sdi_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      shift_reg   <= '0;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      tail_reg    <= 1'b0;
      timeout_cnt <= '0;
      stable_cnt  <= '0;
      retry_cnt   <= '0;
      busy_reg    <= 1'b0;
      locked_reg  <= 1'b0;
      error_reg   <= 1'b0;
      sck_reg     <= 1'b0;
      sen_reg     <= 1'b1;
      sdi_reg     <= 1'b0;
      ld_meta_reg <= 1'b0;
      ld_sync_reg <= 1'b0;
    end else begin
      // Lock evidence only counts once the table is in; each attempt starts fresh.
      if (state_reg == S_WAIT_LOCK || state_reg == S_DONE) begin
        ld_meta_reg <= bus.pll_ld_sdo;
        ld_sync_reg <= ld_meta_reg;
      end else begin
        ld_meta_reg <= 1'b0;
        ld_sync_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE, S_DONE, S_FAIL: begin
          if (state_reg == S_DONE) begin
            locked_reg <= ld_sync_reg;
          end
          if (bus.start) begin
            state_reg  <= S_FETCH;
            busy_reg   <= 1'b1;
            locked_reg <= 1'b0;
            error_reg  <= 1'b0;
            retry_cnt  <= '0;
            addr_reg   <= '0;
          end
        end

        S_FETCH: state_reg <= S_LOAD;

        S_LOAD: begin
          shift_reg <= bus.cfg_data;
          sdi_reg   <= bus.cfg_data[WORD_W-1];
          sen_reg   <= 1'b0;
          sck_reg   <= 1'b0;
          phase_cnt <= '0;
          bit_cnt   <= '0;
          tail_reg  <= 1'b0;
          state_reg <= S_SHIFT;
        end

        S_SHIFT: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (tail_reg) begin
            if (phase_cnt == PH_W'(CLK_DIV - 1)) begin
              sen_reg   <= 1'b1;
              tail_reg  <= 1'b0;
              phase_cnt <= '0;
              if (!last_word && HOP == 0) begin
                addr_reg  <= addr_reg + 1'b1;
                state_reg <= S_FETCH;
              end else begin
                state_reg <= S_GAP;
              end
            end
          end else if (phase_cnt == PH_W'(CLK_DIV - 1)) begin
            sck_reg <= 1'b1;
          end else if (phase_cnt == PH_W'(2 * CLK_DIV - 1)) begin
            // Falling SCK edge: the only point where SDI moves.
            sck_reg   <= 1'b0;
            phase_cnt <= '0;
            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
              tail_reg <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_next;
              sdi_reg   <= shift_next[WORD_W-1];
            end
          end
        end

        S_GAP: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (last_word) begin
            if (phase_cnt == PH_W'(2 * CLK_DIV - 1)) begin
              timeout_cnt <= '0;
              stable_cnt  <= '0;
              state_reg   <= S_WAIT_LOCK;
            end
          end else if (phase_cnt == PH_W'(HOP_LAST)) begin
            addr_reg  <= addr_reg + 1'b1;
            state_reg <= S_FETCH;
          end
        end

        S_WAIT_LOCK: begin
          timeout_cnt <= timeout_cnt + 1'b1;
          stable_cnt  <= ld_sync_reg ? stable_cnt + 1'b1 : '0;
          if (ld_sync_reg && stable_cnt == ST_W'(LOCK_STABLE - 1)) begin
            state_reg  <= S_DONE;
            busy_reg   <= 1'b0;
            locked_reg <= 1'b1;
          end else if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_cnt < RT_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              addr_reg  <= '0;
              state_reg <= S_FETCH;
            end else begin
              state_reg <= S_FAIL;
              busy_reg  <= 1'b0;
              error_reg <= 1'b1;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_spi_loader.sv
// Bench: decodes the SPI pins into words and timing windows and checks them
// against the expected table stream, lock/timeout behaviour and corner cases.
module tb_pll_spi_loader;
  localparam int NWORDS = 2, WORD_W = 24, CLK_DIV = 2;
  localparam int LOCK_TIMEOUT = 50, LOCK_STABLE = 16, MAX_RETRY = 1;

  logic clk, rst_n;
  logic [WORD_W-1:0] rom [NWORDS];
  int tests = 0, fails = 0;

  pll_spi_loader_if #(.ADDR_W(1), .WORD_W(WORD_W)) bus ();

  pll_spi_loader #(
    .NWORDS(NWORDS), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.cfg_data <= rom[bus.cfg_addr];

  // Pin monitor: decoded words, sen windows, gaps and event times.
  logic [WORD_W-1:0] word_q[$];
  int bits_q[$], win_q[$], gap_q[$];
  logic [WORD_W-1:0] cur_word;
  int cur_bits, win_len, gap_len, cyc;
  int t_sen_rise, t_lock, t_busy_fall, t_err;
  bit gap_open;
  logic p_sen = 1'b1, p_sck = 1'b0, p_lock = 1'b0, p_busy = 1'b0, p_err = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.pll_sen === 1'b0) begin
      if (p_sen === 1'b1) begin
        if (gap_open) gap_q.push_back(gap_len);
        win_len = 0; cur_bits = 0; cur_word = '0;
      end
      win_len++;
      if (bus.pll_sck === 1'b1 && p_sck === 1'b0) begin
        cur_word = {cur_word[WORD_W-2:0], bus.pll_sdi};
        cur_bits++;
      end
    end else if (bus.pll_sen === 1'b1) begin
      if (p_sen === 1'b0) begin
        word_q.push_back(cur_word); bits_q.push_back(cur_bits); win_q.push_back(win_len);
        gap_open = 1'b1; gap_len = 0; t_sen_rise = cyc;
      end
      gap_len++;
    end
    if (bus.locked === 1'b1 && p_lock === 1'b0) t_lock = cyc;
    if (bus.busy === 1'b0 && p_busy === 1'b1) t_busy_fall = cyc;
    if (bus.error === 1'b1 && p_err === 1'b0) t_err = cyc;
    p_sen = bus.pll_sen; p_sck = bus.pll_sck; p_lock = bus.locked;
    p_busy = bus.busy; p_err = bus.error;
  end

  task automatic clear_mon();
    word_q.delete(); bits_q.delete(); win_q.delete(); gap_q.delete();
    gap_open = 1'b0; cur_bits = 0; t_lock = -1; t_busy_fall = -1; t_err = -1;
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input bit poke);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      bus.start = (poke && n == 30);
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("busy_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  // Expected stream: whole table once per load attempt.
  task automatic check_stream(input int loads);
    int total = NWORDS * loads;
    check("word_count", word_q.size(), total);
    for (int k = 0; k < total && k < word_q.size(); k++) begin
      check($sformatf("word%0d", k), {8'd0, word_q[k]}, {8'd0, rom[k % NWORDS]});
      check($sformatf("bits%0d", k), bits_q[k], WORD_W);
      check($sformatf("sen_low%0d", k), win_q[k], WORD_W * 2 * CLK_DIV + CLK_DIV);
    end
    check("gap_count", gap_q.size(), total - 1);
    for (int k = 0; k < gap_q.size(); k++)
      check($sformatf("gap%0d", k), gap_q[k],
            ((k + 1) % NWORDS == 0) ? 2 * CLK_DIV + LOCK_TIMEOUT + 2 : 2 * CLK_DIV);
  endtask

  typedef struct {
    logic [WORD_W-1:0] w0, w1;
    bit ld, poke;
    bit exp_locked, exp_error;
    int exp_loads;
  } vec_t;

  function automatic vec_t mk(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                              input bit ld, input bit poke);
    vec_t v;
    v.w0 = a; v.w1 = b; v.ld = ld; v.poke = poke;
    v.exp_locked = ld; v.exp_error = !ld;
    v.exp_loads = ld ? 1 : 1 + MAX_RETRY;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(24'hA50F31, 24'h000001, 1'b1, 1'b0);
    vecs[1] = mk(24'hA50F31, 24'h000001, 1'b0, 1'b0);
    vecs[2] = mk(WORD_W'($urandom), WORD_W'($urandom), 1'b1, 1'b1);
    vecs[3] = mk(WORD_W'($urandom), WORD_W'($urandom), 1'b0, 1'b1);
    vecs[4] = mk(WORD_W'($urandom), WORD_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    vecs[5] = mk(WORD_W'($urandom), WORD_W'($urandom), 1'b1, 1'b0);

    rst_n = 1'b0; bus.start = 1'b0; bus.pll_ld_sdo = 1'b0;
    rom[0] = '0; rom[1] = '0;
    clear_mon();
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset_outs%0d", c),
            {27'd0, bus.pll_sen, bus.pll_sck, bus.busy, bus.locked, bus.error}, 32'b10000);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      rom[0] = vecs[i].w0; rom[1] = vecs[i].w1;
      bus.pll_ld_sdo = vecs[i].ld;
      clear_mon();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_busy", {31'd0, bus.busy}, 32'd1);
      check("start_clears", {30'd0, bus.locked, bus.error}, 32'd0);
      wait_idle(3000, vecs[i].poke);
      check_stream(vecs[i].exp_loads);
      check("final_locked", {31'd0, bus.locked}, {31'd0, vecs[i].exp_locked});
      check("final_error", {31'd0, bus.error}, {31'd0, vecs[i].exp_error});
      if (vecs[i].ld) begin
        check("lock_latency", t_lock - t_sen_rise, 2 * CLK_DIV + LOCK_STABLE + 2);
        check("busy_fall_with_lock", t_busy_fall, t_lock);
        bus.pll_ld_sdo = 1'b0;
        repeat (4) tick();
        check("done_lock_drop", {30'd0, bus.locked, bus.busy}, 32'd0);
        bus.pll_ld_sdo = 1'b1;
        repeat (4) tick();
        check("done_lock_return", {31'd0, bus.locked}, 32'd1);
      end else begin
        check("error_latency", t_err - t_sen_rise, 2 * CLK_DIV + LOCK_TIMEOUT);
      end
      $display("[TB] vec %0d w0=%h w1=%h ld=%0d poke=%0d words=%0d locked=%0d error=%0d",
               i, rom[0], rom[1], vecs[i].ld, vecs[i].poke, word_q.size(), bus.locked, bus.error);
    end

    // Reset during bit 10 of the second word, then a clean reload.
    bus.pll_ld_sdo = 1'b1;
    clear_mon();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    begin
      int n = 0;
      while (!(word_q.size() == 1 && cur_bits == 10) && n < 1000) begin
        tick();
        n++;
      end
      check("reach_bit10", n < 1000, 32'd1);
    end
    rst_n = 1'b0;
    tick();
    check("midword_reset", {29'd0, bus.pll_sen, bus.pll_sck, bus.busy}, 32'b100);
    rst_n = 1'b1;
    tick();
    clear_mon();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("reload_addr0", {31'd0, bus.cfg_addr}, 32'd0);
    wait_idle(3000, 1'b0);
    check_stream(1);
    check("reload_locked", {31'd0, bus.locked}, 32'd1);
    $display("[TB] reset-mid-word reload words=%0d locked=%0d", word_q.size(), bus.locked);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
